// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Status/Cause/EPC/BadVAddr/Count/Compare/PRId/Config,
// Count/Compare timer, hardware interrupt sampling and exception field update.
module cp0_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] badvaddr_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] CP0_REG_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_REG_COUNT    = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_REG_STATUS   = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_REG_EPC      = 5'd14;
  localparam logic [4:0] CP0_REG_PRID     = 5'd15;
  localparam logic [4:0] CP0_REG_CONFIG   = 5'd16;

  localparam logic [31:0] STATUS_RST = 32'h0040_0000;
  localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;
  localparam logic [31:0] PRID_VAL   = 32'h0000_4220;

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        timer_int_q, timer_int_d;
  logic        tick_q, tick_d;
  logic        is_exc;

  always_comb begin
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    compare_d   = compare_q;
    badvaddr_d  = badvaddr_q;
    tick_d      = ~tick_q;
    count_d     = tick_q ? count_q + 32'd1 : count_q;
    timer_int_d = timer_int_q | ((compare_q != '0) && (count_q == compare_q));

    cause_d[15:10] = {int_i[5] | timer_int_q, int_i[4:0]};
    cause_d[30]    = timer_int_q;

    if (we_i) begin
      case (waddr_i)
        CP0_REG_COUNT:   count_d = data_i;
        CP0_REG_COMPARE: begin
          compare_d   = data_i;
          timer_int_d = 1'b0;
        end
        CP0_REG_STATUS: begin
          status_d[15:8] = data_i[15:8];
          status_d[1:0]  = data_i[1:0];
        end
        CP0_REG_CAUSE:   cause_d[9:8] = data_i[9:8];
        CP0_REG_EPC:     epc_d = data_i;
        default: ;
      endcase
    end

    // Exception fields are applied after the mtc0 write so they win per field;
    // the EXL test uses the pre-edge Status so nested exceptions keep EPC/BD.
    is_exc = excepttype_i inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
    if (is_exc) begin
      if (!status_q[1]) begin
        epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = (excepttype_i == 32'h1) ? 5'h00 : excepttype_i[4:0];
      if (excepttype_i == 32'h4 || excepttype_i == 32'h5)
        badvaddr_d = bad_addr_i;
    end else if (excepttype_i == 32'he) begin
      status_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q    <= STATUS_RST;
      cause_q     <= '0;
      epc_q       <= '0;
      count_q     <= '0;
      compare_q   <= '0;
      badvaddr_q  <= '0;
      timer_int_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      badvaddr_q  <= badvaddr_d;
      timer_int_q <= timer_int_d;
      tick_q      <= tick_d;
    end
  end

  always_comb begin
    data_o = '0;
    case (raddr_i)
      CP0_REG_BADVADDR: data_o = badvaddr_q;
      CP0_REG_COUNT:    data_o = count_q;
      CP0_REG_COMPARE:  data_o = compare_q;
      CP0_REG_STATUS:   data_o = status_q;
      CP0_REG_CAUSE:    data_o = cause_q;
      CP0_REG_EPC:      data_o = epc_q;
      CP0_REG_PRID:     data_o = PRID_VAL;
      CP0_REG_CONFIG:   data_o = CONFIG_VAL;
      default:          data_o = '0;
    endcase
  end

  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign badvaddr_o  = badvaddr_q;
  assign config_o    = CONFIG_VAL;
  assign prid_o      = PRID_VAL;
  assign timer_int_o = timer_int_q;

endmodule

// File: doc/cp0_reg.md
# cp0_reg

Coprocessor-0 register file for the five-stage MIPS core. It holds Status, Cause, EPC, BadVAddr, Count, Compare, PRId and Config, and runs the Count/Compare timer. It latches hardware interrupt lines into Cause. Each cycle it takes the exception code and victim PC resolved in MEM, updates EXL/ExcCode/BD/EPC/BadVAddr, and feeds Status/Cause/EPC back to the exception-priority logic.

## Interface
- No parameters. Register addresses use `CP0_REG_BADVADDR`(8), `CP0_REG_COUNT`(9), `CP0_REG_COMPARE`(11), `CP0_REG_STATUS`(12), `CP0_REG_CAUSE`(13), `CP0_REG_EPC`(14), `CP0_REG_PRID`(15), `CP0_REG_CONFIG`(16) from defines.vh.
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- we_i  in  1  mtc0 write enable (W stage).
- waddr_i  in  5  mtc0 target register.
- data_i  in  32  mtc0 write data.
- raddr_i  in  5  mfc0 source register.
- int_i  in  6  hardware interrupt lines hw5..hw0, level-sensitive.
- excepttype_i  in  32  resolved code: 0x1 int, 0x4 adel, 0x5 ades, 0x8 syscall, 0x9 break, 0xa ri, 0xc ov, 0xe eret, 0 none.
- current_inst_addr_i  in  32  PC of the excepting instruction.
- is_in_delayslot_i  in  1  excepting instruction is in a branch delay slot.
- bad_addr_i  in  32  faulting address for adel/ades.
- data_o  out  32  mfc0 read data.
- status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o, config_o, prid_o  out  32 each  register contents.
- timer_int_o  out  1  Count/Compare timer interrupt pending.

## Operation
- Reset values:
  - status = 0x0040_0000 (BEV=1, IM=0, EXL=0, IE=0).
  - cause, epc, count, compare, badvaddr = 0.
  - timer_int_o = 0.
  - Internal count tick = 0.
  - config = 0x0000_8000 and prid = 0x0000_4220 are constants.
- Count: a 1-bit tick toggles every cycle. Count increments by 1 (mod 2^32) on cycles where tick = 1, i.e. at half the core rate.
- Timer: when compare != 0 and count == compare, timer_int_o is set to 1 at the next edge. It stays set until Compare is written, which clears it.
- Cause.IP[15:10] is loaded from int_i every cycle; bit 15 is int_i[5] | timer_int_o. Cause.TI (bit 30) = timer_int_o.
- mtc0 write masks:
  - Status: only IM[15:8], EXL[1], IE[0] are written; all other bits hold.
  - Cause: only IP[9:8] (software interrupts).
  - EPC, Count, Compare: full 32 bits.
  - BadVAddr, PRId, Config: read-only; writes are ignored.
- Exception update, excepttype_i ∈ {0x1, 0x4, 0x5, 0x8, 0x9, 0xa, 0xc}:
  - If Status.EXL = 0: EPC = current_inst_addr_i − 4 and Cause.BD = 1 when is_in_delayslot_i, else EPC = current_inst_addr_i and BD = 0.
  - If Status.EXL = 1: EPC and BD hold.
  - Always: Status.EXL = 1.
  - Cause.ExcCode[6:2] = 0x00 for int; otherwise equals excepttype_i[4:0].
  - adel/ades additionally load BadVAddr = bad_addr_i.
- eret (0xe): Status.EXL = 0; nothing else changes.
- Simultaneous mtc0 and exception in the same cycle: the write applies first, then exception fields override. This holds field by field, so a written IM/IE survives while the exception sets EXL.
- Simultaneous Count write and increment: the write wins.
- Read: data_o is combinational from raddr_i over the current register state, with no same-cycle write bypass. Unlisted addresses read 0.
- rst = 1 mid-operation restores every register to its reset value at that edge, overriding any write or exception.

## Timing
- All register updates occur on the rising edge of clk; results are visible on outputs in the following cycle.
- Exception-to-EXL/EPC latency: 1 cycle.
- int_i to Cause.IP latency: 1 cycle.
- Compare match to timer_int_o: 1 cycle after count reaches compare.
- Count after reset deassertion: 0, 1, 1, 2, 2, … — the first increment lands on the 2nd edge.
- No handshake: excepttype_i is a single-cycle pulse per exception, and the pipeline flushes the following cycle.

## Test plan
- Reset, then idle 10 cycles → status = 0x0040_0000, cause = epc = badvaddr = 0, count = 5, timer_int_o = 0.
- mtc0 Status = 0xFFFF_FFFF → status reads 0x0040_FF03; mtc0 PRId = 0 → prid remains 0x0000_4220.
- excepttype_i = 0xc, current_inst_addr_i = 0xBFC0_0100, delayslot = 1, EXL = 0 → epc = 0xBFC0_00FC, cause[31] = 1, cause[6:2] = 0x0C, status[1] = 1. Then 0xe → status[1] = 0, epc unchanged.
- Exception 0x4 with bad_addr_i = 0x8000_0003 while EXL = 1 → badvaddr = 0x8000_0003, epc holds its prior value, ExcCode = 0x04.
- Write compare = 6, count = 0 → timer_int_o rises one cycle after count == 6, cause[15] = cause[30] = 1. Write compare = 0 → timer_int_o = 0 next cycle.
- Same cycle: mtc0 Status = 0x0000_0401 plus excepttype_i = 0x8 → status = 0x0040_0403, ExcCode = 0x08.
